// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module : simon_pkg
// Brief  : Direction codes, front-end FSM states and vector helpers.
// Rev    : 1.0
// ============================================================================
package simon_pkg;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
    ST_BLOCKED = 2'd2
  } dir_state_e;

  function automatic int popcount32(input logic [31:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) cnt++;
    end
    return cnt;
  endfunction

  // Bit index of a one-hot vector; -1 for zero or multi-hot.
  function automatic int onehot_index(input logic [31:0] vec);
    int idx;
    idx = -1;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = i;
    end
    return (popcount32(vec) == 1) ? idx : -1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module : key_debounce
// Brief  : Two-flop synchroniser plus counter debounce for one raw key.
// Rev    : 1.0
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = KEY_ACTIVE_LOW ? ~raw : raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Accept the new level only after DEBOUNCE_CYCLES consecutive differing samples.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = ~stable_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/debounced_direction_select.sv
`default_nettype none
// ============================================================================
// Module : debounced_direction_select
// Brief  : Debounced direction keys -> level code, press events (valid/ready), collisions.
// Rev    : 1.0
// ============================================================================
module debounced_direction_select #(
  parameter int NUM_KEYS        = 4,
  parameter int CODE_W          = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [CODE_W-1:0]   dir_level,
  output logic [CODE_W-1:0]   dir_code,
  output logic                dir_valid,
  input  logic                dir_ready,
  output logic                overrun,
  output logic                multi_key
);

  import simon_pkg::*;

  logic [NUM_KEYS-1:0] deb;

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
      ) u_key_debounce (
        .clock  (clock),
        .resetn (resetn),
        .raw    (keys[i]),
        .stable (deb[i])
      );
    end
  endgenerate

  dir_state_e        state_q, state_d;
  logic [CODE_W-1:0] dir_level_q, dir_level_d;
  logic [CODE_W-1:0] dir_code_q, dir_code_d;
  logic              dir_valid_q, dir_valid_d;
  logic              overrun_q, overrun_d;
  logic              multi_key_q, multi_key_d;
  int                oh_idx;
  logic [CODE_W-1:0] oh_code;

  always_comb begin
    oh_idx      = onehot_index(32'(deb));
    oh_code     = CODE_W'(oh_idx);
    dir_level_d = (oh_idx >= 0) ? oh_code : {CODE_W{1'b1}};
    multi_key_d = popcount32(32'(deb)) > 1;
    state_d     = state_q;
    dir_code_d  = dir_code_q;
    dir_valid_d = dir_valid_q;
    overrun_d   = 1'b0;

    if (dir_valid_q && dir_ready) dir_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (oh_idx >= 0) begin
          state_d = ST_HELD;
          // A press arriving while the consumer stalls is dropped and flagged.
          if (!dir_valid_q || dir_ready) begin
            dir_code_d  = oh_code;
            dir_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (deb != '0) begin
          state_d = ST_BLOCKED;
        end
      end
      ST_HELD, ST_BLOCKED: begin
        if (deb == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dir_level_q <= '1;
      dir_code_q  <= '1;
      dir_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_level_q <= dir_level_d;
      dir_code_q  <= dir_code_d;
      dir_valid_q <= dir_valid_d;
      overrun_q   <= overrun_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign dir_level = dir_level_q;
  assign dir_code  = dir_code_q;
  assign dir_valid = dir_valid_q;
  assign overrun   = overrun_q;
  assign multi_key = multi_key_q;

endmodule
`default_nettype wire

// File: tb/tb_debounced_direction_select.sv
`default_nettype none
// ============================================================================
// Module : tb_debounced_direction_select
// Brief  : Directed stimulus with event scoreboard for debounced_direction_select.
// Rev    : 1.0
// ============================================================================
module tb_debounced_direction_select;

  import simon_pkg::*;

  localparam int NUM_KEYS = 4;
  localparam int CODE_W   = 3;
  localparam int DEB      = 4;

  logic                clock     = 1'b0;
  logic                resetn    = 1'b0;
  logic [NUM_KEYS-1:0] keys      = '0;
  logic                dir_ready = 1'b1;
  logic [CODE_W-1:0]   dir_level;
  logic [CODE_W-1:0]   dir_code;
  logic                dir_valid;
  logic                overrun;
  logic                multi_key;

  int                n_cmp = 0;
  int                n_err = 0;
  logic [CODE_W-1:0] exp_q[$];
  logic [CODE_W-1:0] exp_code;

  always #5 clock = ~clock;

  debounced_direction_select #(
    .NUM_KEYS        (NUM_KEYS),
    .CODE_W          (CODE_W),
    .DEBOUNCE_CYCLES (DEB),
    .KEY_ACTIVE_LOW  (1'b0)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .keys      (keys),
    .dir_level (dir_level),
    .dir_code  (dir_code),
    .dir_valid (dir_valid),
    .dir_ready (dir_ready),
    .overrun   (overrun),
    .multi_key (multi_key)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Every accepted handshake must match the oldest expected event.
  always @(negedge clock) begin
    if (resetn && dir_valid && dir_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0)
      else begin
        n_err++;
        $error("FAIL sb_unexpected: observed code %0h expected no event", dir_code);
      end
      if (exp_q.size() > 0) begin
        exp_code = exp_q.pop_front();
        n_cmp++;
        assert (dir_code === exp_code)
        else begin
          n_err++;
          $error("FAIL sb_code: observed %0h expected %0h", dir_code, exp_code);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_level", dir_level, DIR_NONE);
    check("rst_code", dir_code, DIR_NONE);
    check("rst_valid", dir_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_multi", multi_key, 0);
    resetn = 1'b1;
    tick(2);

    // 1: single press, valid at cycle 7, level tracks release
    keys = 4'b0001;
    exp_q.push_back(DIR_UP);
    tick(DEB + 2);
    check("t1_valid_c6", dir_valid, 0);
    check("t1_level_c6", dir_level, DIR_NONE);
    tick(1);
    check("t1_valid_c7", dir_valid, 1);
    check("t1_code_c7", dir_code, DIR_UP);
    check("t1_level_c7", dir_level, DIR_UP);
    tick(1);
    check("t1_valid_c8", dir_valid, 0);
    tick(12);
    keys = 4'b0000;
    tick(DEB + 2);
    check("t1_level_rel6", dir_level, DIR_UP);
    tick(1);
    check("t1_level_rel7", dir_level, DIR_NONE);
    tick(2);

    // 2: 3-cycle glitch is rejected
    keys = 4'b0010;
    tick(3);
    keys = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t2_level", dir_level, DIR_NONE);
      check("t2_valid", dir_valid, 0);
    end

    // 3: chord blocks, then single press after release
    keys = 4'b0101;
    tick(DEB + 3);
    check("t3_multi", multi_key, 1);
    check("t3_level", dir_level, DIR_NONE);
    check("t3_valid", dir_valid, 0);
    keys = 4'b0000;
    tick(DEB + 4);
    check("t3_multi_rel", multi_key, 0);
    keys = 4'b0100;
    exp_q.push_back(DIR_DOWN);
    tick(DEB + 3);
    check("t3_valid2", dir_valid, 1);
    check("t3_code2", dir_code, DIR_DOWN);
    keys = 4'b0000;
    tick(DEB + 4);

    // 4: stalled consumer, second press overruns
    dir_ready = 1'b0;
    keys = 4'b1000;
    exp_q.push_back(DIR_LEFT);
    tick(DEB + 3);
    check("t4_valid1", dir_valid, 1);
    check("t4_code1", dir_code, DIR_LEFT);
    keys = 4'b0000;
    tick(DEB + 4);
    keys = 4'b0100;
    tick(DEB + 2);
    check("t4_ovr_c6", overrun, 0);
    tick(1);
    check("t4_ovr_c7", overrun, 1);
    check("t4_valid_c7", dir_valid, 1);
    check("t4_code_c7", dir_code, DIR_LEFT);
    tick(1);
    check("t4_ovr_c8", overrun, 0);
    dir_ready = 1'b1;
    tick(1);
    check("t4_valid_drop", dir_valid, 0);
    check("t4_code_hold", dir_code, DIR_LEFT);
    keys = 4'b0000;
    tick(DEB + 4);

    // 5: extra key added while held is ignored
    keys = 4'b0001;
    exp_q.push_back(DIR_UP);
    tick(DEB + 3);
    check("t5_valid", dir_valid, 1);
    check("t5_level1", dir_level, DIR_UP);
    tick(3);
    keys = 4'b0011;
    tick(DEB + 3);
    check("t5_level2", dir_level, DIR_NONE);
    check("t5_multi", multi_key, 1);
    check("t5_valid2", dir_valid, 0);
    keys = 4'b0000;
    tick(DEB + 4);
    check("t5_level3", dir_level, DIR_NONE);

    // 6: reset mid-press clears at once; held key yields a new event
    dir_ready = 1'b0;
    keys = 4'b0010;
    exp_q.push_back(DIR_RIGHT);
    tick(DEB + 3);
    check("t6_valid_pre", dir_valid, 1);
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", dir_valid, 0);
    check("t6_rst_code", dir_code, DIR_NONE);
    check("t6_rst_level", dir_level, DIR_NONE);
    check("t6_rst_multi", multi_key, 0);
    check("t6_rst_overrun", overrun, 0);
    void'(exp_q.pop_front());
    @(posedge clock);
    #1;
    resetn = 1'b1;
    dir_ready = 1'b1;
    exp_q.push_back(DIR_RIGHT);
    tick(DEB + 2);
    check("t6_valid_c6", dir_valid, 0);
    tick(1);
    check("t6_valid_c7", dir_valid, 1);
    check("t6_code_c7", dir_code, DIR_RIGHT);
    keys = 4'b0000;
    tick(DEB + 6);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
